egress_pri_scheduler: RTL and testbench
=======================================

// Module: egress_pri_scheduler
// PURPOSE
//  Per-output-port packet scheduler between the priority queue manager and one switch output port.
//  Picks which priority queue sends its next packet, based on queue occupancy and the per-priority
//  downstream ready bits. Holds the grant for the whole packet, from the request until the EOP beat.
//  One instance per output port (num_of_ports instances at switch level).
// PARAMETERS
//  num_of_priority  8    number of priority queues per port; index num_of_priority-1 = highest
//  max_beats        64   longest legal packet in data beats (data_width words)
//  weight_width     4    WRR credit width (used only with EGRESS_WRR_EN)
// PORTS
//  clk          in   1                  core clock
//  rst_n        in   1                  asynchronous active-low reset
//  q_nonempty   in   num_of_priority    bit p=1: queue p holds at least one complete packet
//  ready        in   num_of_priority    bit p=1: downstream accepts priority p
//  deq_req      out  1                  dequeue request to queue manager
//  deq_pri      out  clog2(num_of_priority)  priority being requested / served
//  deq_ack      in   1                  one-cycle pulse: manager accepted request, packet follows
//  pkt_vld      in   1                  beat of granted packet on rd_data this cycle
//  pkt_eop      in   1                  last beat (qualified by pkt_vld)
//  busy         out  1                  scheduler in GRANT or XFER
//  len_err      out  1                  sticky: packet exceeded max_beats
//  cfg_weight   in   num_of_priority*weight_width  WRR weights, [p*W +: W] (only with EGRESS_WRR_EN)
// BEHAVIOUR
//  Reset (async assert, sync deassert): state=IDLE, deq_req=0, deq_pri=0, busy=0, len_err=0,
//   beat_cnt=0, WRR credits=0, rr_ptr=0. Reset mid-packet drops the grant with no flush; the queue
//   manager is reset in the same domain.
//  eligible = q_nonempty & ready (combinational, sampled only in IDLE).
//  FSM:
//   IDLE : eligible==0 -> stay. Otherwise register selected pri into deq_pri, deq_req<=1, -> GRANT.
//   GRANT: deq_req and deq_pri held stable. No retraction, even if eligible[deq_pri] drops.
//          deq_ack=1 -> deq_req<=0, beat_cnt<=0, -> XFER.
//   XFER : each pkt_vld increments beat_cnt, saturating at max_beats.
//          pkt_vld&pkt_eop -> IDLE. If beat_cnt==max_beats and another pkt_vld arrives without eop,
//          len_err<=1 (sticky until reset). Stay in XFER until eop.
//  busy = (state!=IDLE), registered.
//  Latency:
//   - eligible asserted in IDLE -> deq_req high next cycle.
//   - eop beat -> IDLE next cycle -> next deq_req one cycle later (min 1 idle cycle between packets).
//  deq_ack outside GRANT, pkt_vld outside XFER: ignored.
//  deq_ack and eop in the same cycle are not possible by FSM; no special case.
//  beat_cnt width clog2(max_beats+1).
// CONFIGURATION
//  EGRESS_WRR_EN undefined: strict priority. Highest eligible index wins; cfg_weight port absent.
//  EGRESS_WRR_EN defined: weighted round robin.
//   - Per-priority credit[p] (weight_width bits).
//   - Select: first eligible p with credit[p]!=0, searching upward from rr_ptr with wrap.
//     On selection credit[p]-=1 and rr_ptr<=p+1 (mod num_of_priority).
//   - If no eligible p has credit!=0: reload all credit[p]<=cfg_weight[p] and select in the same
//     cycle using the reloaded values.
//   - weight 0: priority never served while others are eligible.
//     If all eligible weights are 0, fall back to strict priority.
// TESTING
//  1 reset: rst_n low mid-XFER -> deq_req=0, busy=0, len_err=0 immediately; after release stay IDLE
//    while eligible==0.
//  2 strict: q_nonempty=8'h24, ready=8'hFF -> deq_req=1, deq_pri=5 next cycle; ack; 4 beats + eop
//    -> IDLE, then deq_pri=2.
//  3 ready mask: q_nonempty=8'h80, ready=8'h7F -> no request; ready[7] rises -> deq_pri=7 after 1 cycle.
//  4 hold: in GRANT drop q_nonempty[deq_pri] before ack -> deq_req/deq_pri unchanged until deq_ack.
//  5 len_err: max_beats=64, send 65 beats before eop -> len_err=1 on beat 65, stays 1 after eop.
//  6 EGRESS_WRR_EN: weights p0=1, p1=3, both always eligible -> grant sequence over 8 packets
//    has ratio 1:3 (p0,p1,p1,p1 repeating).

Source files
------------

// File: rtl/egress_pri_scheduler.sv
// egress_pri_scheduler
//   Per-output-port packet scheduler. Chooses which priority queue sends its
//   next packet from queue occupancy and per-priority downstream ready, then
//   holds that grant from request until the EOP beat of the packet.
//
//   Selection policy:
//     EGRESS_WRR_EN undefined : strict priority, highest eligible index wins.
//     EGRESS_WRR_EN defined   : weighted round robin using cfg_weight credits,
//                               falling back to strict priority when every
//                               eligible queue has weight 0.
//
//   Ports
//     clk, rst_n   core clock, asynchronous active-low reset
//     q_nonempty   per-priority: queue holds at least one complete packet
//     ready        per-priority: downstream accepts that priority
//     deq_req      dequeue request to the queue manager (registered)
//     deq_pri      priority being requested / served (registered)
//     deq_ack      one-cycle accept pulse from the queue manager
//     pkt_vld      beat of the granted packet present this cycle
//     pkt_eop      last beat of the packet (qualified by pkt_vld)
//     busy         scheduler in GRANT or XFER (registered)
//     cfg_weight   WRR weights, priority p at [p*weight_width +: weight_width]
//                  (present only with EGRESS_WRR_EN)
//     len_err      sticky: a packet ran past max_beats
module egress_pri_scheduler #(
  parameter int unsigned num_of_priority = 8,
  parameter int unsigned max_beats       = 64,
  parameter int unsigned weight_width    = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [num_of_priority-1:0]             q_nonempty,
  input  logic [num_of_priority-1:0]             ready,
  output logic                                   deq_req,
  output logic [$clog2(num_of_priority)-1:0]     deq_pri,
  input  logic                                   deq_ack,
  input  logic                                   pkt_vld,
  input  logic                                   pkt_eop,
  output logic                                   busy,
`ifdef EGRESS_WRR_EN
  input  logic [num_of_priority*weight_width-1:0] cfg_weight,
`endif
  output logic                                   len_err
);

  localparam int unsigned pri_w = $clog2(num_of_priority);
  localparam int unsigned cnt_w = $clog2(max_beats + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [num_of_priority-1:0] eligible;
  logic [pri_w-1:0]         strict_pri;
  logic [pri_w-1:0]         sel_pri;
  logic [cnt_w-1:0]         beat_cnt;
  logic [cnt_w-1:0]         beat_cnt_nxt;
  logic                     deq_req_nxt;
  logic [pri_w-1:0]         deq_pri_nxt;
  logic                     busy_nxt;
  logic                     len_err_nxt;

  // Only looked at while IDLE; a grant is never retracted afterwards.
  assign eligible = q_nonempty & ready;

  // Highest eligible index.
  always_comb begin
    strict_pri = '0;
    for (int unsigned p = 0; p < num_of_priority; p++) begin
      if (eligible[p]) strict_pri = pri_w'(p);
    end
  end

`ifdef EGRESS_WRR_EN
  logic [weight_width-1:0]    credit_q   [num_of_priority];
  logic [weight_width-1:0]    credit_eff [num_of_priority];
  logic [weight_width-1:0]    credit_nxt [num_of_priority];
  logic [pri_w-1:0]           rr_ptr;
  logic [pri_w-1:0]           rr_ptr_nxt;
  logic [num_of_priority-1:0] has_credit;
  logic [num_of_priority-1:0] cand;
  logic                       reload;
  logic                       wrr_found;
  logic [pri_w-1:0]           wrr_pri;
  int unsigned                idx;

  // Credits are reloaded from cfg_weight when no eligible queue has credit
  // left; the search then runs on the reloaded values in the same cycle.
  always_comb begin
    has_credit = '0;
    for (int unsigned p = 0; p < num_of_priority; p++) begin
      has_credit[p] = eligible[p] & (credit_q[p] != '0);
    end
    reload = (has_credit == '0);
    for (int unsigned p = 0; p < num_of_priority; p++) begin
      credit_eff[p] = reload ? cfg_weight[p*weight_width +: weight_width] : credit_q[p];
    end
    cand = '0;
    for (int unsigned p = 0; p < num_of_priority; p++) begin
      cand[p] = eligible[p] & (credit_eff[p] != '0);
    end
    wrr_found = 1'b0;
    wrr_pri   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < num_of_priority; k++) begin
      idx = (32'(rr_ptr) + k) % num_of_priority;
      if (!wrr_found && cand[pri_w'(idx)]) begin
        wrr_found = 1'b1;
        wrr_pri   = pri_w'(idx);
      end
    end
  end

  // All-zero-weight eligible set falls back to strict priority.
  always_comb begin
    sel_pri = wrr_found ? wrr_pri : strict_pri;
  end

  // Credit / pointer update on each IDLE selection.
  always_comb begin
    credit_nxt = credit_q;
    rr_ptr_nxt = rr_ptr;
    if ((state == ST_IDLE) && (eligible != '0)) begin
      credit_nxt = credit_eff;
      if (wrr_found) begin
        credit_nxt[wrr_pri] = credit_eff[wrr_pri] - weight_width'(1);
        rr_ptr_nxt = (wrr_pri == pri_w'(num_of_priority - 1)) ? '0 : wrr_pri + pri_w'(1);
      end
    end
  end

  // WRR state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      for (int unsigned p = 0; p < num_of_priority; p++) credit_q[p] <= '0;
    end else begin
      rr_ptr   <= rr_ptr_nxt;
      credit_q <= credit_nxt;
    end
  end
`else
  always_comb begin
    sel_pri = strict_pri;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (eligible != '0)     state_nxt = ST_GRANT;
      ST_GRANT: if (deq_ack)            state_nxt = ST_XFER;
      ST_XFER:  if (pkt_vld && pkt_eop) state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and beat counter.
  always_comb begin
    deq_req_nxt  = deq_req;
    deq_pri_nxt  = deq_pri;
    len_err_nxt  = len_err;
    beat_cnt_nxt = beat_cnt;
    busy_nxt     = (state_nxt != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (eligible != '0) begin
          deq_req_nxt = 1'b1;
          deq_pri_nxt = sel_pri;
        end
      end
      ST_GRANT: begin
        if (deq_ack) begin
          deq_req_nxt  = 1'b0;
          beat_cnt_nxt = '0;
        end
      end
      ST_XFER: begin
        // Counter saturates; a further non-EOP beat marks an overlong packet.
        if (pkt_vld) begin
          if (beat_cnt == cnt_w'(max_beats)) begin
            if (!pkt_eop) len_err_nxt = 1'b1;
          end else begin
            beat_cnt_nxt = beat_cnt + cnt_w'(1);
          end
        end
      end
      default: begin
        deq_req_nxt = 1'b0;
      end
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deq_req  <= 1'b0;
      deq_pri  <= '0;
      busy     <= 1'b0;
      len_err  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      deq_req  <= deq_req_nxt;
      deq_pri  <= deq_pri_nxt;
      busy     <= busy_nxt;
      len_err  <= len_err_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_egress_pri_scheduler.sv
// tb_egress_pri_scheduler
//   Bench for egress_pri_scheduler: a packet-level reference model compared
//   against the DUT every cycle, plus directed scenarios with literal values.
module tb_egress_pri_scheduler;

  localparam int NP = 8;
  localparam int MB = 64;
  localparam int WW = 4;

  typedef int cred_t [NP];

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP-1:0]   q_nonempty = '0;
  logic [NP-1:0]   ready = '0;
  logic            deq_req;
  logic [2:0]      deq_pri;
  logic            deq_ack = 1'b0;
  logic            pkt_vld = 1'b0;
  logic            pkt_eop = 1'b0;
  logic            busy;
  logic            len_err;
`ifdef EGRESS_WRR_EN
  logic [NP*WW-1:0] cfg_weight = 32'h0000_0031;   // p0=1, p1=3, rest 0
`endif

  int n_pass = 0;
  int n_total = 0;
  bit run_cmp = 1'b0;

  egress_pri_scheduler #(
    .num_of_priority(NP),
    .max_beats(MB),
    .weight_width(WW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .q_nonempty(q_nonempty),
    .ready(ready),
    .deq_req(deq_req),
    .deq_pri(deq_pri),
    .deq_ack(deq_ack),
    .pkt_vld(pkt_vld),
    .pkt_eop(pkt_eop),
    .busy(busy),
`ifdef EGRESS_WRR_EN
    .cfg_weight(cfg_weight),
`endif
    .len_err(len_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // phase: 0 waiting for an eligible queue, 1 request outstanding, 2 packet moving
  int    m_phase = 0;
  bit    m_req = 1'b0;
  int    m_pri = 0;
  bit    m_len_err = 1'b0;
  int    m_beats = 0;
`ifdef EGRESS_WRR_EN
  cred_t m_credit = '{default: 0};
  int    m_rr = 0;
`endif

  function automatic int top_pri(input logic [NP-1:0] e);
    int r = 0;
    for (int i = 0; i < NP; i++) if (e[i]) r = i;
    return r;
  endfunction

`ifdef EGRESS_WRR_EN
  task automatic wrr_pick(input logic [NP-1:0] elig, input cred_t cin, input int rin,
                          output int pk, output cred_t cout, output int rout);
    bit any = 1'b0;
    cout = cin;
    rout = rin;
    pk   = -1;
    for (int i = 0; i < NP; i++) if (elig[i] && cout[i] > 0) any = 1'b1;
    if (!any) for (int i = 0; i < NP; i++) cout[i] = int'(cfg_weight[i*WW +: WW]);
    for (int k = 0; k < NP; k++) begin
      int i = (rin + k) % NP;
      if (pk < 0 && elig[i] && cout[i] > 0) pk = i;
    end
    if (pk >= 0) begin
      cout[pk] = cout[pk] - 1;
      rout = (pk + 1) % NP;
    end else begin
      pk = top_pri(elig);
    end
  endtask
`endif

  always @(posedge clk or negedge rst_n) begin : model
    int p;
`ifdef EGRESS_WRR_EN
    cred_t nc;
    int nr;
`endif
    if (!rst_n) begin
      m_phase   <= 0;
      m_req     <= 1'b0;
      m_pri     <= 0;
      m_len_err <= 1'b0;
      m_beats   <= 0;
`ifdef EGRESS_WRR_EN
      m_rr      <= 0;
      m_credit  <= '{default: 0};
`endif
    end else begin
      case (m_phase)
        0: if ((q_nonempty & ready) != '0) begin
`ifdef EGRESS_WRR_EN
             wrr_pick(q_nonempty & ready, m_credit, m_rr, p, nc, nr);
             m_credit <= nc;
             m_rr     <= nr;
`else
             p = top_pri(q_nonempty & ready);
`endif
             m_pri   <= p;
             m_req   <= 1'b1;
             m_phase <= 1;
           end
        1: if (deq_ack) begin
             m_req   <= 1'b0;
             m_beats <= 0;
             m_phase <= 2;
           end
        default: if (pkt_vld) begin
             if (m_beats >= MB && !pkt_eop) m_len_err <= 1'b1;
             m_beats <= (m_beats + 1 > MB) ? MB : m_beats + 1;
             if (pkt_eop) m_phase <= 0;
           end
      endcase
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      check("cmp_deq_req", int'(deq_req), int'(m_req));
      check("cmp_deq_pri", int'(deq_pri), m_pri);
      check("cmp_busy",    int'(busy),    int'(m_phase != 0));
      check("cmp_len_err", int'(len_err), int'(m_len_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_ack();
    deq_ack = 1'b1;
    cyc();
    deq_ack = 1'b0;
  endtask

  // n non-EOP beats followed by one EOP beat.
  task automatic send_pkt(input int n);
    for (int i = 0; i < n; i++) begin
      pkt_vld = 1'b1;
      pkt_eop = 1'b0;
      cyc();
    end
    pkt_vld = 1'b1;
    pkt_eop = 1'b1;
    cyc();
    pkt_vld = 1'b0;
    pkt_eop = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (deq_req) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    if (!ok) check("req_timeout", 0, 1);
  endtask

  initial begin
    int exp_seq [8];
    bit ok;

    // reset values
    cyc(1);
    run_cmp = 1'b1;
    cyc(1);
    check("rst_req", int'(deq_req), 0);
    check("rst_pri", int'(deq_pri), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_len_err", int'(len_err), 0);
    rst_n = 1'b1;
    cyc(3);
    check("idle_hold_req", int'(deq_req), 0);

    // strict priority: 5 beats 2, then 2 served after the packet
    ready = 8'hFF;
    q_nonempty = 8'h24;
    cyc();
    check("t2_req", int'(deq_req), 1);
    check("t2_pri", int'(deq_pri), 5);
    check("t2_busy", int'(busy), 1);
    q_nonempty = 8'h04;
    do_ack();
    check("t2_ack_req", int'(deq_req), 0);
    send_pkt(4);
    check("t2_eop_busy", int'(busy), 0);
    check("t2_eop_req", int'(deq_req), 0);
    cyc();
    check("t2_next_req", int'(deq_req), 1);
    check("t2_next_pri", int'(deq_pri), 2);
    q_nonempty = 8'h00;
    do_ack();
    send_pkt(0);
    cyc(2);

    // ready mask
    q_nonempty = 8'h80;
    ready = 8'h7F;
    cyc(3);
    check("t3_masked_req", int'(deq_req), 0);
    check("t3_masked_busy", int'(busy), 0);
    ready = 8'hFF;
    cyc();
    check("t3_req", int'(deq_req), 1);
    check("t3_pri", int'(deq_pri), 7);

    // grant hold while eligibility drops
    q_nonempty = 8'h00;
    cyc(3);
    check("t4_hold_req", int'(deq_req), 1);
    check("t4_hold_pri", int'(deq_pri), 7);
    ready = 8'h00;
    cyc();
    check("t4_hold_req2", int'(deq_req), 1);
    ready = 8'hFF;
    do_ack();
    check("t4_ack_req", int'(deq_req), 0);
    send_pkt(1);
    cyc(2);

    // overlong packet
    q_nonempty = 8'h02;
    cyc();
    check("t5_pri", int'(deq_pri), 1);
    q_nonempty = 8'h00;
    do_ack();
    for (int i = 0; i < MB; i++) begin
      pkt_vld = 1'b1;
      pkt_eop = 1'b0;
      cyc();
    end
    check("t5_no_err_at_64", int'(len_err), 0);
    cyc();
    check("t5_err_at_65", int'(len_err), 1);
    pkt_eop = 1'b1;
    cyc();
    pkt_vld = 1'b0;
    pkt_eop = 1'b0;
    check("t5_err_after_eop", int'(len_err), 1);
    check("t5_idle", int'(busy), 0);
    cyc(2);
    check("t5_err_sticky", int'(len_err), 1);

    // reset in the middle of a transfer
    q_nonempty = 8'h08;
    cyc();
    check("t1_pri", int'(deq_pri), 3);
    q_nonempty = 8'h00;
    do_ack();
    pkt_vld = 1'b1;
    cyc(2);
    pkt_vld = 1'b0;
    check("t1_busy_xfer", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("t1_rst_req", int'(deq_req), 0);
    check("t1_rst_busy", int'(busy), 0);
    check("t1_rst_len_err", int'(len_err), 0);
    check("t1_rst_pri", int'(deq_pri), 0);
    cyc();
    rst_n = 1'b1;
    cyc(3);
    check("t1_post_req", int'(deq_req), 0);
    check("t1_post_busy", int'(busy), 0);
    // ack / beats outside their states are ignored
    deq_ack = 1'b1;
    pkt_vld = 1'b1;
    pkt_eop = 1'b1;
    cyc();
    deq_ack = 1'b0;
    pkt_vld = 1'b0;
    pkt_eop = 1'b0;
    check("ignored_busy", int'(busy), 0);
    check("ignored_len_err", int'(len_err), 0);

    // back-to-back packets with p0 and p1 both eligible
`ifdef EGRESS_WRR_EN
    exp_seq = '{0, 1, 1, 1, 0, 1, 1, 1};
`else
    exp_seq = '{1, 1, 1, 1, 1, 1, 1, 1};
`endif
    q_nonempty = 8'h03;
    for (int k = 0; k < 8; k++) begin
      wait_req(ok);
      if (ok) begin
        check($sformatf("seq_pri_%0d", k), int'(deq_pri), exp_seq[k]);
        do_ack();
        send_pkt(1);
      end
    end
    q_nonempty = 8'h00;
    cyc(4);

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
